// File: rtl/cpu_stream_arbiter_pkg.sv
// Shared types and defaults for the cpu stream arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_arb_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    localparam int N_CPU_DEF  = 4;
    localparam int DATA_W_DEF = 64;
    localparam int CNT_W_DEF  = 32;

    // Source index width; never collapses to zero bits for small N.
    function automatic int src_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cpu_stream_arbiter_if.sv
// Bundle of producer-side and sink-side signals of the cpu stream arbiter.
// Latency: n/a (wiring only).
// Backpressure: cpu_rdy per source, out_rdy from the sink.
// Ports: cpu_vld/cpu_data/cpu_done/cpu_rdy (producers), out_vld/out_data/out_src/out_rdy (sink),
//        src_cnt/total_cnt/all_done (status). master = arbiter side, slave = environment side.
interface cpu_stream_arbiter_if #(
    parameter int N_CPU  = cpu_arb_pkg::N_CPU_DEF,
    parameter int DATA_W = cpu_arb_pkg::DATA_W_DEF,
    parameter int CNT_W  = cpu_arb_pkg::CNT_W_DEF
);
    import cpu_arb_pkg::*;

    localparam int SRC_W = src_w(N_CPU);

    logic [N_CPU-1:0]             cpu_vld;
    logic [N_CPU-1:0][DATA_W-1:0] cpu_data;
    logic [N_CPU-1:0]             cpu_done;
    logic [N_CPU-1:0]             cpu_rdy;
    logic                         out_vld;
    logic [DATA_W-1:0]            out_data;
    logic [SRC_W-1:0]             out_src;
    logic                         out_rdy;
    logic [N_CPU-1:0][CNT_W-1:0]  src_cnt;
    logic [CNT_W-1:0]             total_cnt;
    logic                         all_done;

    modport master (
        input  cpu_vld, cpu_data, cpu_done, out_rdy,
        output cpu_rdy, out_vld, out_data, out_src, src_cnt, total_cnt, all_done
    );

    modport slave (
        output cpu_vld, cpu_data, cpu_done, out_rdy,
        input  cpu_rdy, out_vld, out_data, out_src, src_cnt, total_cnt, all_done
    );

endinterface

// File: rtl/cpu_stream_arbiter_rr_pick.sv
// Rotating-priority picker: first requester at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
// Ports: req[N] requests, ptr highest-priority index; gnt_vld any request, gnt_idx chosen index.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_vld,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] idx;

    // Scan from the farthest candidate to the nearest so the nearest hit is written last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/cpu_stream_arbiter.sv
// Round-robin merge of N_CPU producers into one sink through a single output register, with counters and completion flag.
// Latency: 1 cycle from input transfer to out_vld; 1 beat/cycle when the sink is always ready.
// Backpressure: a beat held with out_rdy low blocks every cpu_rdy; no beat is overwritten or dropped.
// Ports: clk, rst_n (async active-low), bus (master modport): producer handshakes, sink handshake, counters, all_done.
module cpu_stream_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int N_CPU  = N_CPU_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cpu_stream_arbiter_if.master  bus
);

    localparam int SRC_W = src_w(N_CPU);

    logic                         can_accept;
    logic                         in_xfer;
    logic                         out_xfer;
    logic                         gnt_vld;
    logic [SRC_W-1:0]             gnt_idx;
    logic [SRC_W-1:0]             gnt_next;
    logic [N_CPU-1:0]             cpu_rdy_c;

    logic [SRC_W-1:0]             rr_ptr;
    logic                         out_vld_q;
    logic [DATA_W-1:0]            out_data_q;
    logic [SRC_W-1:0]             out_src_q;
    logic [N_CPU-1:0][CNT_W-1:0]  src_cnt_q;
    logic [CNT_W-1:0]             total_cnt_q;
    logic                         all_done_q;
    arb_state_e                   state;

    rr_pick #(.N(N_CPU), .W(SRC_W)) u_pick (
        .req     (bus.cpu_vld),
        .ptr     (rr_ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    assign can_accept = !out_vld_q || bus.out_rdy;
    assign out_xfer   = out_vld_q && bus.out_rdy;
    assign gnt_next   = (gnt_idx == SRC_W'(N_CPU - 1)) ? '0 : gnt_idx + SRC_W'(1);

    // Ready goes only to the picked source, so any set bit is a transfer.
    // Gating with rst_n keeps cpu_rdy low while reset is held.
    always_comb begin
        cpu_rdy_c = '0;
        if (rst_n && gnt_vld && can_accept && state != DONE) begin
            cpu_rdy_c[gnt_idx] = 1'b1;
        end
    end

    assign in_xfer = |cpu_rdy_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            src_cnt_q   <= '0;
            total_cnt_q <= '0;
            all_done_q  <= 1'b0;
            state       <= RUN;
        end else begin
            // A refill in the same cycle as a drain keeps out_vld high.
            if (in_xfer) begin
                out_vld_q          <= 1'b1;
                out_data_q         <= bus.cpu_data[gnt_idx];
                out_src_q          <= gnt_idx;
                src_cnt_q[gnt_idx] <= src_cnt_q[gnt_idx] + CNT_W'(1);
                rr_ptr             <= gnt_next;
            end else if (out_xfer) begin
                out_vld_q <= 1'b0;
            end

            if (out_xfer) begin
                total_cnt_q <= total_cnt_q + CNT_W'(1);
            end

            // cpu_done is only looked at in RUN, so it may drop later without effect.
            case (state)
                RUN: begin
                    if (&bus.cpu_done) state <= DRAIN;
                end
                DRAIN: begin
                    if (!out_vld_q || out_xfer) begin
                        state      <= DONE;
                        all_done_q <= 1'b1;
                    end
                end
                DONE:    ;
                default: state <= RUN;
            endcase
        end
    end

    assign bus.cpu_rdy   = cpu_rdy_c;
    assign bus.out_vld   = out_vld_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.src_cnt   = src_cnt_q;
    assign bus.total_cnt = total_cnt_q;
    assign bus.all_done  = all_done_q;

    a_rdy_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(cpu_rdy_c));

    a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (out_vld_q && !bus.out_rdy) |=> (out_vld_q && $stable(out_data_q) && $stable(out_src_q)));

endmodule

// File: tb/tb_cpu_stream_arbiter.sv
// Randomized and directed stimulus for cpu_stream_arbiter against a transaction-level reference model.
// Latency: n/a (testbench).
// Backpressure: out_rdy is driven randomly and in directed stall windows.
module tb_cpu_stream_arbiter;
    import cpu_arb_pkg::*;

    localparam int N    = 4;
    localparam int DW   = 64;
    localparam int CW   = 32;
    localparam int CW_S = 4;
    localparam longint MASK   = (64'd1 << CW) - 1;
    localparam longint MASK_S = (64'd1 << CW_S) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_stream_arbiter_if #(.N_CPU(N), .DATA_W(DW), .CNT_W(CW))   bus ();
    cpu_stream_arbiter_if #(.N_CPU(N), .DATA_W(DW), .CNT_W(CW_S)) sbus ();

    // The narrow-counter instance sees exactly the same traffic.
    assign sbus.cpu_vld  = bus.cpu_vld;
    assign sbus.cpu_data = bus.cpu_data;
    assign sbus.cpu_done = bus.cpu_done;
    assign sbus.out_rdy  = bus.out_rdy;

    cpu_stream_arbiter #(.N_CPU(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cpu_stream_arbiter #(.N_CPU(N), .DATA_W(DW), .CNT_W(CW_S)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] data;
        int            src;
    } beat_t;

    beat_t         slot[$];      // output stage: holds at most one beat
    int            m_ptr;        // source with highest priority next
    longint        m_src[N];
    longint        m_total;
    int            m_phase;      // 0 collecting, 1 waiting for drain, 2 finished
    logic [DW-1:0] m_last_data;
    int            m_last_src;

    logic [N-1:0]  t_vld;
    logic [N-1:0]  t_done;
    logic          t_ordy;
    logic [DW-1:0] t_data[N];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        slot.delete();
        m_ptr       = 0;
        m_total     = 0;
        m_phase     = 0;
        m_last_data = '0;
        m_last_src  = 0;
        for (int i = 0; i < N; i++) m_src[i] = 0;
    endtask

    task automatic check_regs();
        chk("out_vld", 64'(bus.out_vld), 64'(slot.size() != 0));
        chk("out_data", bus.out_data, m_last_data);
        chk("out_src", 64'(bus.out_src), 64'(m_last_src));
        chk("all_done", 64'(bus.all_done), 64'(m_phase == 2));
        chk("total_cnt", 64'(bus.total_cnt), m_total & MASK);
        chk("total_cnt_s", 64'(sbus.total_cnt), m_total & MASK_S);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("src_cnt[%0d]", i), 64'(bus.src_cnt[i]), m_src[i] & MASK);
            chk($sformatf("src_cnt_s[%0d]", i), 64'(sbus.src_cnt[i]), m_src[i] & MASK_S);
        end
    endtask

    // One clock: drive inputs, check ready, advance the model, check registered state.
    task automatic step();
        int           g;
        logic [N-1:0] exp_rdy;
        bit           was_empty;
        bit           deliver;
        beat_t        b;
        bus.cpu_vld  = t_vld;
        bus.cpu_done = t_done;
        bus.out_rdy  = t_ordy;
        for (int i = 0; i < N; i++) bus.cpu_data[i] = t_data[i];
        #1;
        g       = -1;
        exp_rdy = '0;
        if (m_phase != 2 && (slot.size() == 0 || t_ordy)) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (g < 0 && t_vld[i]) g = i;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("cpu_rdy", 64'(bus.cpu_rdy), 64'(exp_rdy));
        chk("cpu_rdy_s", 64'(sbus.cpu_rdy), 64'(exp_rdy));

        was_empty = (slot.size() == 0);
        deliver   = !was_empty && t_ordy;
        if (deliver) begin
            void'(slot.pop_front());
            m_total++;
        end
        if (g >= 0) begin
            b.data = t_data[g];
            b.src  = g;
            slot.push_back(b);
            m_src[g]++;
            m_ptr       = (g + 1) % N;
            m_last_data = t_data[g];
            m_last_src  = g;
        end
        if (m_phase == 0 && (&t_done)) m_phase = 1;
        else if (m_phase == 1 && (was_empty || deliver)) m_phase = 2;

        @(posedge clk);
        @(negedge clk);
        check_regs();
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) t_data[i] = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_vld", 64'(bus.out_vld), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_out_src", 64'(bus.out_src), 64'd0);
        chk("rst_cpu_rdy", 64'(bus.cpu_rdy), 64'd0);
        chk("rst_total", 64'(bus.total_cnt), 64'd0);
        chk("rst_all_done", 64'(bus.all_done), 64'd0);
        for (int i = 0; i < N; i++) chk($sformatf("rst_src_cnt[%0d]", i), 64'(bus.src_cnt[i]), 64'd0);
        model_reset();
        t_vld  = '0;
        t_done = '0;
        t_ordy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_regs();
    endtask

    initial begin
        rst_n  = 1'b0;
        t_vld  = '0;
        t_done = '0;
        t_ordy = 1'b0;
        rand_data();
        bus.cpu_vld  = '0;
        bus.cpu_done = '0;
        bus.out_rdy  = 1'b0;
        for (int i = 0; i < N; i++) bus.cpu_data[i] = '0;
        @(negedge clk);
        do_reset();

        // All sources requesting, sink always ready: strict rotation, full rate.
        t_vld  = 4'b1111;
        t_ordy = 1'b1;
        for (int c = 0; c < 400; c++) begin
            rand_data();
            step();
        end
        for (int i = 0; i < N; i++) chk($sformatf("fair_cnt[%0d]", i), 64'(bus.src_cnt[i]), 64'd100);

        // Lone requester is served every cycle.
        t_vld = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            rand_data();
            step();
        end

        // Random traffic and random backpressure.
        for (int c = 0; c < 2000; c++) begin
            rand_data();
            t_vld  = N'($urandom);
            t_ordy = ($urandom_range(0, 3) != 0);
            step();
        end

        // Held beat under a 10-cycle stall.
        t_vld  = '0;
        t_ordy = 1'b1;
        step();
        rand_data();
        t_data[0] = 64'hDEAD_BEEF_DEAD_BEEF;
        t_vld     = 4'b0001;
        t_ordy    = 1'b0;
        step();
        t_vld = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            rand_data();
            step();
        end
        chk("bp_hold_data", bus.out_data, 64'hDEAD_BEEF_DEAD_BEEF);
        t_vld  = '0;
        t_ordy = 1'b1;
        step();
        step();

        // Reset while the output stage holds a beat.
        t_vld  = 4'b1111;
        t_ordy = 1'b0;
        rand_data();
        step();
        step();
        chk("pre_rst_vld", 64'(bus.out_vld), 64'd1);
        do_reset();
        t_ordy = 1'b1;
        for (int c = 0; c < 3; c++) step();

        // Counter wrap: 17 beats from source 1 on the 4-bit-counter instance.
        t_vld  = 4'b0010;
        t_ordy = 1'b1;
        for (int c = 0; c < 17; c++) begin
            rand_data();
            step();
        end
        t_vld = '0;
        step();
        chk("wrap_src1_s", 64'(sbus.src_cnt[1]), 64'd1);
        chk("wrap_total_s", 64'(sbus.total_cnt), 64'd1);
        chk("wrap_src1", 64'(bus.src_cnt[1]), 64'd17);

        // Completion: done ramps while the last beat is stalled.
        rand_data();
        t_vld  = 4'b0001;
        t_ordy = 1'b0;
        step();
        t_vld = '0;
        for (int c = 0; c < N; c++) begin
            t_done = N'((1 << (c + 1)) - 1);
            step();
        end
        t_done = '0;
        step();
        step();
        chk("drain_not_done", 64'(bus.all_done), 64'd0);
        t_ordy = 1'b1;
        step();
        chk("all_done_rise", 64'(bus.all_done), 64'd1);
        t_vld = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            rand_data();
            step();
        end
        chk("done_rdy_zero", 64'(bus.cpu_rdy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
